// File: rtl/dds_wave_reader.sv
// dds_wave_reader: loads a waveform table into a single-port RAM, then plays it
// back as a DDS phase accumulator with a validity strobe aligned to RAM latency.
module dds_wave_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_DEPTH  = 256,
    parameter int PHASE_WIDTH = 32,
    parameter int RD_LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_start,
    input  logic                          ld_valid,
    input  logic [DATA_WIDTH-1:0]         ld_data,
    output logic                          ld_ready,
    output logic                          ld_done,
    input  logic                          run_en,
    input  logic [PHASE_WIDTH-1:0]        freq_word,
    input  logic [PHASE_WIDTH-1:0]        phase_off,
    output logic                          ram_wea,
    output logic [$clog2(DATA_DEPTH)-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wr_data,
    input  logic [DATA_WIDTH-1:0]         ram_re_data,
    output logic [DATA_WIDTH-1:0]         wave_out,
    output logic                          wave_valid,
    output logic                          busy
);

    // state | meaning
    // IDLE  | waiting for ld_start (priority) or run_en; read pipe may still drain
    // LOAD  | accepting table words, one RAM write per ld_valid
    // RUN   | issuing one phase-derived read address per cycle while run_en is high

    localparam int AW = $clog2(DATA_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                 state, state_nxt;
    logic [AW-1:0]          cnt;
    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] phase_sum;
    logic [RD_LATENCY:0]    pipe, pipe_nxt;
    logic                   accept, last_word, issue;

    assign phase_sum = acc + phase_off;
    assign pipe_nxt  = {pipe[RD_LATENCY-1:0], issue};

    // Next-state decode plus per-cycle load/read qualifiers.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_word = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start)    state_nxt = LOAD;
                else if (run_en) state_nxt = RUN;
            end
            LOAD: begin
                accept    = ld_valid;
                last_word = ld_valid && (cnt == AW'(DATA_DEPTH - 1));
                if (last_word) state_nxt = IDLE;
            end
            RUN: begin
                issue = run_en;
                if (!run_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: load counter, phase accumulator, RAM port, read pipe and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            pipe        <= '0;
            ram_wea     <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            ld_ready    <= 1'b0;
            ld_done     <= 1'b0;
            wave_out    <= '0;
            wave_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ram_wea <= accept;
            if (accept) begin
                ram_addr    <= cnt;
                ram_wr_data <= ld_data;
                cnt         <= cnt + 1'b1;
            end else if (issue) begin
                ram_addr <= phase_sum[PHASE_WIDTH-1 -: AW];
                acc      <= acc + freq_word;
            end
            // Entry clears happen only from IDLE, so they never collide with the updates above.
            if (state == IDLE && state_nxt == LOAD) cnt <= '0;
            if (state == IDLE && state_nxt == RUN)  acc <= '0;

            ld_ready <= (state_nxt == LOAD);
            ld_done  <= last_word;

            // The tail bit lines up with ram_re_data for the address issued RD_LATENCY+1 cycles ago.
            pipe       <= pipe_nxt;
            wave_valid <= pipe[RD_LATENCY];
            if (pipe[RD_LATENCY]) wave_out <= ram_re_data;

            busy <= (state_nxt != IDLE) || (pipe_nxt != '0);
        end
    end

endmodule

// File: tb/tb_dds_wave_reader.sv
// Directed bench for dds_wave_reader with a 2-cycle-latency single-port RAM model.
module tb_dds_wave_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_start, ld_valid, ld_ready, ld_done, run_en;
    logic [7:0]  ld_data;
    logic [31:0] freq_word, phase_off;
    logic        ram_wea;
    logic [7:0]  ram_addr, ram_wr_data, ram_re_data;
    logic [7:0]  wave_out;
    logic        wave_valid, busy;

    int checks   = 0;
    int failures = 0;
    int run_step = 0;

    logic [7:0] mem [256];
    logic [7:0] addr_q;

    always #5 clk = ~clk;

    // RAM model: input address register then output data register.
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addr] <= ram_wr_data;
        addr_q      <= ram_addr;
        ram_re_data <= mem[addr_q];
    end

    dds_wave_reader #(
        .DATA_WIDTH(8), .DATA_DEPTH(256), .PHASE_WIDTH(32), .RD_LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done),
        .run_en(run_en), .freq_word(freq_word), .phase_off(phase_off),
        .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .ram_re_data(ram_re_data),
        .wave_out(wave_out), .wave_valid(wave_valid), .busy(busy)
    );

    task automatic test_reset();
        rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        run_en = 1'b0; freq_word = 32'h0; phase_off = 32'h0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({ram_wea, ld_ready, ld_done, wave_valid, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {ram_wea, ld_ready, ld_done, wave_valid, busy});
        end
        checks++;
        if ({ram_addr, ram_wr_data, wave_out} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=000000", {ram_addr, ram_wr_data, wave_out});
        end
        rst_n = 1'b1;
        ld_valid = 1'b1; ld_data = 8'hAA;
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_wea, ld_ready, busy} !== 3'b0) begin
            failures++;
            $display("FAIL idle_drop_valid got=%b exp=000", {ram_wea, ld_ready, busy});
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_load_gaps();
        int n = 0;
        int c = 0;
        logic v;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL gaps_ready got=%b exp=1", ld_ready);
        end
        while (n < 256 && c < 1000) begin
            v = (c % 2 == 0);
            ld_valid = v;
            ld_data  = 8'(n) ^ 8'h5A;
            @(negedge clk);
            checks++;
            if (ram_wea !== v) begin
                failures++;
                $display("FAIL gaps_wea cyc=%0d got=%b exp=%b", c, ram_wea, v);
            end
            if (v) begin
                checks++;
                if (ram_addr !== 8'(n) || ram_wr_data !== (8'(n) ^ 8'h5A)) begin
                    failures++;
                    $display("FAIL gaps_write n=%0d got=%h/%h exp=%h/%h", n, ram_addr, ram_wr_data, 8'(n), 8'(n) ^ 8'h5A);
                end
                n++;
            end
            checks++;
            if (ld_done !== (v && n == 256)) begin
                failures++;
                $display("FAIL gaps_done n=%0d got=%b exp=%b", n, ld_done, (v && n == 256));
            end
            c++;
        end
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL gaps_timeout got=%0d exp=256", n);
        end
        ld_valid = 1'b0;
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL gaps_ready_end got=%b exp=0", ld_ready);
        end
        @(negedge clk);
        checks++;
        if ({ld_done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL gaps_idle got=%b exp=00", {ld_done, busy});
        end
    endtask

    task automatic test_load_ramp();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i);
            @(negedge clk);
            checks++;
            if (ram_wea !== 1'b1 || ram_addr !== 8'(i) || ram_wr_data !== 8'(i)) begin
                failures++;
                $display("FAIL ramp_write i=%0d got=%b/%h/%h exp=1/%h/%h", i, ram_wea, ram_addr, ram_wr_data, 8'(i), 8'(i));
            end
            checks++;
            if (ld_done !== (i == 255)) begin
                failures++;
                $display("FAIL ramp_done i=%0d got=%b exp=%b", i, ld_done, (i == 255));
            end
        end
        ld_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({ld_ready, ld_done, ram_wea, busy} !== 4'b0) begin
            failures++;
            $display("FAIL ramp_idle got=%b exp=0000", {ld_ready, ld_done, ram_wea, busy});
        end
    endtask

    task automatic test_run();
        freq_word = 32'h0100_0000;
        phase_off = 32'h0;
        run_en    = 1'b1;
        for (int c = 0; c <= 300; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if ({busy, ld_ready, wave_valid} !== 3'b100) begin
                    failures++;
                    $display("FAIL run_entry got=%b exp=100", {busy, ld_ready, wave_valid});
                end
            end else begin
                checks++;
                if (ram_wea !== 1'b0 || ram_addr !== 8'(c - 1)) begin
                    failures++;
                    $display("FAIL run_addr c=%0d got=%b/%h exp=0/%h", c, ram_wea, ram_addr, 8'(c - 1));
                end
            end
            checks++;
            if (wave_valid !== (c >= 4)) begin
                failures++;
                $display("FAIL run_valid c=%0d got=%b exp=%b", c, wave_valid, (c >= 4));
            end
            if (c >= 4) begin
                checks++;
                if (wave_out !== 8'(c - 4)) begin
                    failures++;
                    $display("FAIL run_sample c=%0d got=%h exp=%h", c, wave_out, 8'(c - 4));
                end
            end
        end
        run_step = 300;
    endtask

    task automatic test_stop_drain();
        run_en = 1'b0;
        for (int m = run_step + 1; m <= run_step + 6; m++) begin
            @(negedge clk);
            checks++;
            if (wave_valid !== (m <= run_step + 3)) begin
                failures++;
                $display("FAIL drain_valid m=%0d got=%b exp=%b", m, wave_valid, (m <= run_step + 3));
            end
            if (m <= run_step + 3) begin
                checks++;
                if (wave_out !== 8'(m - 4)) begin
                    failures++;
                    $display("FAIL drain_sample m=%0d got=%h exp=%h", m, wave_out, 8'(m - 4));
                end
            end
            checks++;
            if (busy !== (m <= run_step + 2)) begin
                failures++;
                $display("FAIL drain_busy m=%0d got=%b exp=%b", m, busy, (m <= run_step + 2));
            end
            checks++;
            if (ram_addr !== 8'(run_step - 1)) begin
                failures++;
                $display("FAIL drain_addr m=%0d got=%h exp=%h", m, ram_addr, 8'(run_step - 1));
            end
        end
    endtask

    task automatic test_phase_offset();
        logic [7:0] exp_v;
        freq_word = 32'h8000_0000;
        phase_off = 32'h4000_0000;
        run_en    = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                exp_v = ((c - 1) % 2 == 0) ? 8'd64 : 8'd192;
                checks++;
                if (ram_addr !== exp_v) begin
                    failures++;
                    $display("FAIL phase_addr c=%0d got=%0d exp=%0d", c, ram_addr, exp_v);
                end
            end
            if (c >= 4) begin
                exp_v = ((c - 4) % 2 == 0) ? 8'd64 : 8'd192;
                checks++;
                if (wave_valid !== 1'b1 || wave_out !== exp_v) begin
                    failures++;
                    $display("FAIL phase_sample c=%0d got=%b/%0d exp=1/%0d", c, wave_valid, wave_out, exp_v);
                end
            end
        end
        run_en = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, wave_valid} !== 2'b00 || wave_out !== 8'd192) begin
            failures++;
            $display("FAIL phase_hold got=%b/%0d exp=00/192", {busy, wave_valid}, wave_out);
        end
    endtask

    task automatic test_priority();
        freq_word = 32'h0100_0000;
        phase_off = 32'h0;
        ld_start  = 1'b1;
        run_en    = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        checks++;
        if ({ld_ready, ram_wea} !== 2'b10) begin
            failures++;
            $display("FAIL prio_load got=%b exp=10", {ld_ready, ram_wea});
        end
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i);
            @(negedge clk);
            checks++;
            if (ram_wea !== 1'b1 || ram_addr !== 8'(i)) begin
                failures++;
                $display("FAIL prio_write i=%0d got=%b/%h exp=1/%h", i, ram_wea, ram_addr, 8'(i));
            end
        end
        ld_valid = 1'b0;
        checks++;
        if ({ld_done, ld_ready} !== 2'b10) begin
            failures++;
            $display("FAIL prio_done got=%b exp=10", {ld_done, ld_ready});
        end
        @(negedge clk);
        checks++;
        if ({busy, ld_ready, ram_wea} !== 3'b100) begin
            failures++;
            $display("FAIL prio_run_entry got=%b exp=100", {busy, ld_ready, ram_wea});
        end
        @(negedge clk);
        checks++;
        if (ram_addr !== 8'd0 || ram_wea !== 1'b0) begin
            failures++;
            $display("FAIL prio_first_addr got=%b/%h exp=0/00", ram_wea, ram_addr);
        end
        run_en = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL prio_busy_end got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid_load();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_wea, ld_ready, ld_done, wave_valid, busy} !== 5'b0 ||
            {ram_addr, ram_wr_data, wave_out} !== 24'h0) begin
            failures++;
            $display("FAIL midload_reset got=%b/%h exp=00000/000000",
                     {ram_wea, ld_ready, ld_done, wave_valid, busy}, {ram_addr, ram_wr_data, wave_out});
        end
        ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ld_ready, busy} !== 2'b00) begin
            failures++;
            $display("FAIL midload_idle got=%b exp=00", {ld_ready, busy});
        end
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'h33;
        @(negedge clk);
        checks++;
        if (ram_wea !== 1'b1 || ram_addr !== 8'd0 || ram_wr_data !== 8'h33) begin
            failures++;
            $display("FAIL midload_restart got=%b/%h/%h exp=1/00/33", ram_wea, ram_addr, ram_wr_data);
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_gaps();
        test_load_ramp();
        test_run();
        test_stop_drain();
        test_phase_offset();
        test_priority();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
